// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with condition codes. Single-cycle operations
//            (add/sub/logic/move) finish through a FIN state. Shifts run
//            bit-serially, one position per cycle. MUL is a shift-add
//            multiplier that takes W cycles.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            start           - request, sampled only while busy=0
//            op, a, b, cin,
//            set_cc          - operation, operands, carry-in and flag
//                              enable, all captured with start
//            busy            - operation in progress
//            done            - one-cycle pulse when result is valid
//            result          - registered result, holds until next done
//            c, n, v, z      - registered condition codes
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int W  = 32,
    parameter int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         set_cc,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         c,
    output logic         n,
    output logic         v,
    output logic         z
);

    localparam logic [4:0] c_op_add   = 5'd0;
    localparam logic [4:0] c_op_addc  = 5'd1;
    localparam logic [4:0] c_op_sub   = 5'd2;
    localparam logic [4:0] c_op_subc  = 5'd3;
    localparam logic [4:0] c_op_and   = 5'd4;
    localparam logic [4:0] c_op_or    = 5'd5;
    localparam logic [4:0] c_op_xor   = 5'd6;
    localparam logic [4:0] c_op_andnb = 5'd7;
    localparam logic [4:0] c_op_nota  = 5'd8;
    localparam logic [4:0] c_op_passb = 5'd9;
    localparam logic [4:0] c_op_lsl   = 5'd10;
    localparam logic [4:0] c_op_lsr   = 5'd11;
    localparam logic [4:0] c_op_asr   = 5'd12;
    localparam logic [4:0] c_op_mul   = 5'd13;

    localparam logic [SW:0] c_mul_cycles = (SW+1)'(W);
    localparam logic [SW:0] c_cnt_one    = (SW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         r_state;
    logic [4:0]     r_op;
    logic [W-1:0]   r_a;        // operand a; shift register / multiplicand in EXEC
    logic [W-1:0]   r_b;        // operand b; multiplier (consumed LSB first) in EXEC
    logic [W-1:0]   r_acc;      // product accumulator
    logic           r_cin;
    logic           r_set_cc;
    logic           r_sh_c;     // last bit shifted out
    logic [SW:0]    r_cnt;      // remaining EXEC steps

    logic           w_multi;
    logic [W:0]     w_ext;
    logic [W-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic           w_legal;

    assign w_multi = (op >= c_op_lsl) && (op <= c_op_mul);

    // Final result and flags, evaluated from captured operands while in FIN.
    always_comb begin
        w_ext   = '0;
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_legal = 1'b1;
        case (r_op)
            c_op_add, c_op_addc: begin
                w_ext = {1'b0, r_a} + {1'b0, r_b}
                      + {{W{1'b0}}, (r_op == c_op_addc) & r_cin};
                w_res = w_ext[W-1:0];
                w_c   = w_ext[W];
                w_v   = (r_a[W-1] == r_b[W-1]) && (w_ext[W-1] != r_a[W-1]);
            end
            c_op_sub, c_op_subc: begin
                // Bit W of the extended difference is the borrow.
                w_ext = {1'b0, r_a} - {1'b0, r_b}
                      - {{W{1'b0}}, (r_op == c_op_subc) & ~r_cin};
                w_res = w_ext[W-1:0];
                w_c   = ~w_ext[W];
                w_v   = (r_a[W-1] != r_b[W-1]) && (w_ext[W-1] != r_a[W-1]);
            end
            c_op_and:   w_res = r_a & r_b;
            c_op_or:    w_res = r_a | r_b;
            c_op_xor:   w_res = r_a ^ r_b;
            c_op_andnb: w_res = r_a & ~r_b;
            c_op_nota:  w_res = ~r_a;
            c_op_passb: w_res = r_b;
            c_op_lsl, c_op_lsr, c_op_asr: begin
                w_res = r_a;
                w_c   = r_sh_c;
            end
            c_op_mul:   w_res = r_acc;
            default:    w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cin    <= 1'b0;
            r_set_cc <= 1'b0;
            r_sh_c   <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            c        <= 1'b0;
            n        <= 1'b0;
            v        <= 1'b0;
            z        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_b      <= b;
                        r_cin    <= cin;
                        r_set_cc <= set_cc;
                        r_acc    <= '0;
                        r_sh_c   <= 1'b0;
                        busy     <= 1'b1;
                        if (op == c_op_mul) begin
                            r_cnt <= c_mul_cycles;
                        end else begin
                            r_cnt <= {1'b0, b[SW-1:0]};
                        end
                        r_state <= w_multi ? S_EXEC : S_FIN;
                    end
                end
                S_EXEC: begin
                    // A zero shift count still spends one cycle here.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                        case (r_op)
                            c_op_lsl: begin
                                r_a    <= {r_a[W-2:0], 1'b0};
                                r_sh_c <= r_a[W-1];
                            end
                            c_op_lsr: begin
                                r_a    <= {1'b0, r_a[W-1:1]};
                                r_sh_c <= r_a[0];
                            end
                            c_op_asr: begin
                                r_a    <= {r_a[W-1], r_a[W-1:1]};
                                r_sh_c <= r_a[0];
                            end
                            default: begin
                                if (r_b[0]) begin
                                    r_acc <= r_acc + r_a;
                                end
                                r_a <= {r_a[W-2:0], 1'b0};
                                r_b <= {1'b0, r_b[W-1:1]};
                            end
                        endcase
                    end
                    if (r_cnt <= c_cnt_one) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    result  <= w_res;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_legal && r_set_cc) begin
                        c <= w_c;
                        v <= w_v;
                        n <= w_res[W-1];
                        z <= (w_res == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (W=32). A behavioural model
//            predicts result, flags, busy and done cycle by cycle from plain
//            arithmetic; directed operations pin known literal answers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         set_cc = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c, n, v, z;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_mc #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .set_cc (set_cc),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c      (c),
        .n      (n),
        .v      (v),
        .z      (z)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit ovf(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic void model_eval(input logic [4:0] o, input logic [31:0] x, y,
                                       input logic ci, output logic [31:0] r,
                                       output bit cc, output bit vv,
                                       output bit legal, output int lat);
        longint unsigned ux, uy, full, bw;
        longint sx, sy;
        int sh;
        ux = 64'(x);
        uy = 64'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        bw = ci ? 64'd0 : 64'd1;
        r = '0; cc = 1'b0; vv = 1'b0; legal = 1'b1; lat = 2;
        case (o)
            5'd0: begin full = ux + uy; r = full[31:0]; cc = full[32]; vv = ovf(sx + sy); end
            5'd1: begin
                full = ux + uy + (ci ? 64'd1 : 64'd0);
                r = full[31:0]; cc = full[32];
                vv = ovf(sx + sy + (ci ? 64'sd1 : 64'sd0));
            end
            5'd2: begin full = ux - uy; r = full[31:0]; cc = (ux >= uy); vv = ovf(sx - sy); end
            5'd3: begin
                full = ux - uy - bw; r = full[31:0]; cc = (ux >= uy + bw);
                vv = ovf(sx - sy - longint'(bw));
            end
            5'd4: r = x & y;
            5'd5: r = x | y;
            5'd6: r = x ^ y;
            5'd7: r = x & ~y;
            5'd8: r = ~x;
            5'd9: r = y;
            5'd10: begin r = x << sh;  cc = (sh == 0) ? 1'b0 : x[32-sh]; end
            5'd11: begin r = x >> sh;  cc = (sh == 0) ? 1'b0 : x[sh-1]; end
            5'd12: begin r = $signed(x) >>> sh; cc = (sh == 0) ? 1'b0 : x[sh-1]; end
            5'd13: begin full = ux * uy; r = full[31:0]; lat = W + 2; end
            default: legal = 1'b0;
        endcase
        if (o >= 5'd10 && o <= 5'd12) lat = (sh == 0) ? 3 : sh + 2;
    endfunction

    int          m_rem = 0;      // edges left until the one that raises done
    bit          m_done = 1'b0;
    logic [31:0] m_res = '0;
    bit          m_c = 0, m_n = 0, m_v = 0, m_z = 0;
    logic [31:0] p_res = '0;
    bit          p_c = 0, p_v = 0, p_legal = 0, p_sc = 0;
    int          p_lat = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_done = 0; m_res = '0;
            m_c = 0; m_n = 0; m_v = 0; m_z = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1;
                    m_res  = p_res;
                    if (p_legal && p_sc) begin
                        m_c = p_c; m_v = p_v;
                        m_n = p_res[31]; m_z = (p_res == 0);
                    end
                end
            end else if (start) begin
                model_eval(op, a, b, cin, p_res, p_c, p_v, p_legal, p_lat);
                p_sc  = set_cc;
                m_rem = p_lat - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cmp_busy",   busy,   m_rem > 0);
            chk("cmp_done",   done,   m_done);
            chk("cmp_result", result, m_res);
            chk("cmp_c", c, m_c);
            chk("cmp_n", n, m_n);
            chk("cmp_v", v, m_v);
            chk("cmp_z", z, m_z);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [4:0] o, input logic [31:0] aa, bb,
                          input logic ci, sc, input bit noise, output int lat);
        int guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, guard);
        end
        start = 1'b1; op = o; a = aa; b = bb; cin = ci; set_cc = sc;
        @(negedge clk);
        start = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom;
        cin = 1'($urandom); set_cc = 1'($urandom);
        lat = 1;
        while (!done && lat < 100) begin
            if (noise) start = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: done %0b, required 1 within 100 cycles", done);
            lat = -1;
        end
    endtask

    task automatic expect_op(input string name, input logic [4:0] o, input logic [31:0] aa, bb,
                             input logic ci, sc, input bit noise, input int exp_lat,
                             input logic [31:0] exp_res, input logic [3:0] exp_nvcz);
        int lat;
        run_op(o, aa, bb, ci, sc, noise, lat);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, result, exp_res);
        chk({name, "_nvcz"}, {n, v, c, z}, exp_nvcz);
    endtask

    initial begin
        int lat;
        logic [4:0] ro;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_nvcz", {n, v, c, z}, 0);

        rst_n = 1'b1;
        chk_en = 1'b1;
        //        name       op     a             b             cin  sc  noise lat  result        nvcz
        expect_op("add_ovf",  5'd0,  32'h7FFFFFFF, 32'h00000001, 0,   1,  0,    2,   32'h80000000, 4'b1100);
        expect_op("sub_eq",   5'd2,  32'h5,        32'h5,        0,   1,  0,    2,   32'h0,        4'b0011);
        expect_op("add_ovf2", 5'd0,  32'h7FFFFFFF, 32'h00000001, 0,   1,  0,    2,   32'h80000000, 4'b1100);
        expect_op("sub_nocc", 5'd2,  32'h5,        32'h5,        0,   0,  0,    2,   32'h0,        4'b1100);
        expect_op("lsl1",     5'd10, 32'h80000001, 32'h1,        0,   1,  0,    3,   32'h00000002, 4'b0010);
        expect_op("asr31",    5'd12, 32'h80000000, 32'd31,       0,   1,  0,    33,  32'hFFFFFFFF, 4'b1000);
        expect_op("lsr0",     5'd11, 32'h12345678, 32'h20,       0,   1,  0,    3,   32'h12345678, 4'b0000);
        expect_op("mul",      5'd13, 32'h0000FFFF, 32'h00010001, 0,   1,  1,    34,  32'hFFFFFFFF, 4'b1000);
        expect_op("illegal",  5'd20, 32'h12345678, 32'h9ABCDEF0, 1,   1,  0,    2,   32'h0,        4'b1000);
        expect_op("add_b2b",  5'd0,  32'h1,        32'h2,        0,   1,  0,    2,   32'h3,        4'b0000);
        expect_op("addc",     5'd1,  32'hFFFFFFFF, 32'h0,        1,   1,  0,    2,   32'h0,        4'b0011);
        expect_op("subc",     5'd3,  32'h0,        32'h0,        0,   1,  0,    2,   32'hFFFFFFFF, 4'b1000);

        // Reset in the middle of a multiply.
        start = 1'b1; op = 5'd13; a = 32'h1234; b = 32'h5678; cin = 0; set_cc = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_nvcz", {n, v, c, z}, 0);
        @(negedge clk);
        chk("arst_hold_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_op("add_post", 5'd0, 32'h2, 32'h3, 0, 1, 0, 2, 32'h5, 4'b0000);

        // Randomized operations, checked cycle by cycle against the model.
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ro = ($urandom_range(0, 19) < 16) ? 5'($urandom_range(0, 13))
                                              : 5'($urandom_range(14, 31));
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: ra = 32'h7FFFFFFF;
                2: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = ra;
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'($urandom), 1'($urandom), 1'b1, lat);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: W, 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 Parameter: SW, $clog2(W), shift-amount width taken from b[SW-1:0].
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request; sampled only when busy=0.
REQ-006 Port: op  input  5  operation code, captured with start.
REQ-007 Port: a, b  input  W each  operands, captured with start.
REQ-008 Port: cin  input  1  carry-in, captured with start.
REQ-009 Port: set_cc  input  1  flag-update enable, captured with start.
REQ-010 Port: busy  output  1  operation in progress; start ignored.
REQ-011 Port: done  output  1  one-cycle pulse; result valid.
REQ-012 Port: result  output  W  registered result; holds until next done.
REQ-013 Port: c, n, v, z  output  1 each  registered condition codes.

Function
REQ-014 Opcodes: 0 ADD a+b; 1 ADDC a+b+cin; 2 SUB a-b; 3 SUBC a-b-!cin; 4 AND; 5 OR; 6 XOR; 7 ANDNB a&~b; 8 NOTA ~a; 9 PASSB b; 10 LSL; 11 LSR; 12 ASR (a by b[SW-1:0]); 13 MUL low W bits of a*b unsigned; 14-31 illegal.
REQ-015 FSM states IDLE, EXEC, FIN; reset state IDLE.
REQ-016 IDLE: start=1 captures a, b, op, cin, set_cc; single-cycle ops (0-9, illegal) go to FIN; ops 10-13 go to EXEC.
REQ-017 EXEC shifts: one bit position per cycle, shamt cycles; shamt=0 goes directly to FIN after one EXEC cycle with result=a.
REQ-018 EXEC MUL: shift-add, one multiplier bit per cycle, exactly W cycles.
REQ-019 FIN: result and flags written, done=1 for exactly that cycle, next state IDLE.
REQ-020 busy=1 in EXEC and FIN; busy=0 in IDLE; start while busy=1 is ignored, not queued.
REQ-021 Latency start-accept to done: single-cycle ops 2 cycles; shifts shamt+2 (shamt=0: 2... via one EXEC cycle, i.e. 3); MUL W+2.
REQ-022 Arithmetic computed at W+1 bits; c = bit W for ADD/ADDC; c = 1 when no borrow for SUB/SUBC.
REQ-023 v = true two's-complement signed overflow for ops 0-3 (operand signs equal/differ vs result sign); v=0 for all other ops.
REQ-024 Logic ops, NOTA, PASSB, MUL: c=0; shifts: c = last bit shifted out, 0 if shamt=0.
REQ-025 z = (result==0), n = result[W-1], for every legal op.
REQ-026 Flags updated in FIN only when captured set_cc=1; otherwise hold previous values; result always updated.
REQ-027 Illegal op: result=0, flags unchanged regardless of set_cc, done still pulses.
REQ-028 Input changes after capture do not affect the operation in progress.

Reset
REQ-029 rst_n=0 immediately forces IDLE, busy=0, done=0, result=0, c=n=v=z=0, including mid-EXEC; aborted operation produces no done.
REQ-030 First start is accepted on the first rising edge with rst_n=1.

Verification
REQ-031 W=32, ADD a=7FFFFFFF b=1 set_cc=1 -> done 2 cycles after start, result=80000000, n=1 v=1 c=0 z=0.
REQ-032 SUB a=5 b=5 set_cc=1 -> result=0, z=1 c=1 v=0 n=0; repeat with set_cc=0 after ADD -> flags retain prior values.
REQ-033 LSL a=80000001 b=1 -> result=00000002, c=1, done 3 cycles after start; ASR a=80000000 b=31 -> FFFFFFFF.
REQ-034 MUL a=0000FFFF b=00010001 -> result=FFFFFFFF, done W+2=34 cycles after start; second start pulsed mid-operation ignored.
REQ-035 rst_n low during MUL cycle 10 -> busy=0, result=0, flags 0 asynchronously; no done; new ADD after release completes normally.
REQ-036 op=20 -> result=0, done pulses, c/n/v/z unchanged; start on cycle after done accepted.
